// File: rtl/lsu.sv
// Load/store unit: turns byte-addressed RISC-V loads/stores into word accesses.
// Sub-word stores use a registered read-modify-write, so memory read data never
// reaches the write data combinationally.
module lsu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req,
  input  logic             i_wr,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_done,
  output logic             o_stall,
  output logic             o_err,
  output logic [WIDTH-1:0] o_mem_a,
  input  logic [WIDTH-1:0] i_mem_rd,
  output logic             o_mem_we,
  output logic [WIDTH-1:0] o_mem_wd
);

  typedef enum logic {StIdle, StMerge} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cap_a;
  logic [WIDTH-1:0] r_mrg;
  logic [WIDTH-1:0] w_merged;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_load;
  logic             w_legal;
  logic             w_misal;
  logic             w_err;
  logic             w_sub_store;
  logic             w_capture;

  // Decode legality, alignment and store kind of the incoming request
  always_comb begin
    w_legal = 1'b0;
    w_misal = 1'b0;
    if (i_wr) begin
      w_legal = i_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      w_legal = i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    case (i_funct3[1:0])
      2'b01:   w_misal = i_addr[0];
      2'b10:   w_misal = |i_addr[1:0];
      default: w_misal = 1'b0;
    endcase
    w_err       = ~w_legal | w_misal;
    w_sub_store = i_wr & (i_funct3[1:0] != 2'b10);
  end

  // Align the addressed lane(s) to bit 0 and extend; halves are aligned, so a
  // byte-granular shift also serves them
  always_comb begin
    w_shifted = i_mem_rd >> {i_addr[1:0], 3'b000};
    w_load    = '0;
    case (i_funct3)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load = w_shifted;
      3'b100:  w_load = {24'd0, w_shifted[7:0]};
      3'b101:  w_load = {16'd0, w_shifted[15:0]};
      default: w_load = '0;
    endcase
  end

  // Replace the addressed lane(s) of the current word with the store data
  always_comb begin
    w_merged = i_mem_rd;
    if (i_funct3[1:0] == 2'b00) begin
      w_merged[{i_addr[1:0], 3'b000} +: 8] = i_wdata[7:0];
    end else begin
      w_merged[{i_addr[1], 4'b0000} +: 16] = i_wdata[15:0];
    end
  end

  // Next-state and output decode; reset forces all handshake/write outputs low
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    o_rdata     = '0;
    o_done      = 1'b0;
    o_stall     = 1'b0;
    o_err       = 1'b0;
    o_mem_a     = {2'b00, i_addr[WIDTH-1:2]};
    o_mem_we    = 1'b0;
    o_mem_wd    = '0;
    unique case (r_state)
      StIdle: begin
        if (i_req) begin
          if (w_err) begin
            o_done = 1'b1;
            o_err  = 1'b1;
          end else if (!i_wr) begin
            o_rdata = w_load;
            o_done  = 1'b1;
          end else if (!w_sub_store) begin
            o_mem_we = 1'b1;
            o_mem_wd = i_wdata;
            o_done   = 1'b1;
          end else begin
            o_stall     = 1'b1;
            w_capture   = 1'b1;
            w_state_nxt = StMerge;
          end
        end
      end
      StMerge: begin
        o_mem_a     = r_cap_a;
        o_mem_we    = 1'b1;
        o_mem_wd    = r_mrg;
        o_done      = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    if (!i_rst_n) begin
      o_rdata  = '0;
      o_done   = 1'b0;
      o_stall  = 1'b0;
      o_err    = 1'b0;
      o_mem_we = 1'b0;
    end
  end

  // State register plus captured address and merged word for the write cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cap_a <= '0;
      r_mrg   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_cap_a <= {2'b00, i_addr[WIDTH-1:2]};
        r_mrg   <= w_merged;
      end
    end
  end

endmodule
